// File: rtl/hazard_unit_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hazard_unit_mc
// Brief    : Pipeline hazard unit with operand forwarding, load-use stall,
//            multicycle execute FSM and a saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_unit_mc #(
  parameter int AW     = 4,
  parameter int NSRC   = 3,
  parameter int MC_LAT = 4,
  parameter int LD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NSRC*AW-1:0]   RA_D,
  input  logic [NSRC*AW-1:0]   RA_E,
  input  logic [AW-1:0]        WA_E,
  input  logic [AW-1:0]        WA_M,
  input  logic [AW-1:0]        WA_W,
  input  logic                 RegWriteE,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 MemtoRegE,
  input  logic                 PCSrcD,
  input  logic                 PCSrcE,
  input  logic                 PCSrcM,
  input  logic                 PCSrcW,
  input  logic                 BranchTakenE,
  input  logic                 MultiStartE,
  output logic [NSRC*2-1:0]    ForwardE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushM,
  output logic                 McBusy,
  output logic [15:0]          StallCount
);

  localparam logic [3:0] c_mc_load = 4'(MC_LAT - 2);
  localparam logic [1:0] c_ld_load = 2'(LD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_mc_cnt;
  logic        r_mc_busy;
  logic        r_mc_stall;
  logic [1:0]  r_ld_cnt;
  logic [15:0] r_stall_cnt;

  logic [NSRC*2-1:0] w_fwd;
  logic [NSRC-1:0]   w_ld_match;
  logic              w_ld_detect;
  logic              w_ld_stall;
  logic              w_pc_pend;
  logic              w_mc_start;
  logic              w_stall_f;

  generate
    for (genvar i = 0; i < NSRC; i++) begin : g_src
      // M-stage result is newer than W-stage, so it wins on a double match
      assign w_fwd[i*2 +: 2] =
        (RegWriteM && (RA_E[i*AW +: AW] == WA_M)) ? 2'b10 :
        (RegWriteW && (RA_E[i*AW +: AW] == WA_W)) ? 2'b01 : 2'b00;
      assign w_ld_match[i] = (RA_D[i*AW +: AW] == WA_E);
    end
  endgenerate

  assign w_ld_detect = MemtoRegE && RegWriteE && (|w_ld_match);
  assign w_ld_stall  = !r_mc_stall && ((r_ld_cnt != 2'd0) || w_ld_detect);
  assign w_pc_pend   = PCSrcD || PCSrcE || PCSrcM;
  assign w_mc_start  = MultiStartE && !BranchTakenE;
  assign w_stall_f   = r_mc_stall || w_ld_stall || w_pc_pend;

  // Combinational paths are gated so every output is low while reset is held
  assign ForwardE = reset ? w_fwd : '0;
  assign StallF   = reset && w_stall_f;
  assign StallD   = reset && (r_mc_stall || w_ld_stall);
  assign StallE   = reset && r_mc_stall;
  assign FlushE   = reset && !r_mc_stall && (w_ld_stall || BranchTakenE);
  assign FlushD   = reset && !r_mc_stall && !w_ld_stall &&
                    (BranchTakenE || w_pc_pend || PCSrcW);
  assign FlushM   = reset && r_mc_stall;
  assign McBusy   = reset && r_mc_busy;
  assign StallCount = r_stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_mc_cnt   <= 4'd0;
      r_mc_busy  <= 1'b0;
      r_mc_stall <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mc_start) begin
            r_state    <= S_BUSY;
            r_mc_cnt   <= c_mc_load;
            r_mc_busy  <= 1'b1;
            r_mc_stall <= 1'b1;
          end
        end
        S_BUSY: begin
          if (r_mc_cnt == 4'd0) begin
            r_state    <= S_DONE;
            r_mc_stall <= 1'b0;
          end else begin
            r_mc_cnt <= r_mc_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_mc_busy <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_mc_busy  <= 1'b0;
          r_mc_stall <= 1'b0;
        end
      endcase
    end
  end

  // Load counter freezes under a multicycle stall; the hazard is re-seen afterwards
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ld_cnt <= 2'd0;
    end else if (!r_mc_stall) begin
      if (r_ld_cnt != 2'd0) begin
        r_ld_cnt <= r_ld_cnt - 2'd1;
      end else if (w_ld_detect) begin
        r_ld_cnt <= c_ld_load;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= 16'd0;
    end else if (w_stall_f && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hazard_unit_mc
// Brief    : Scoreboard bench for hazard_unit_mc (LD_LAT=2, MC_LAT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_unit_mc;
  localparam int AW = 4;
  localparam int NSRC = 3;
  // {StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy}
  localparam logic [6:0] P_NONE = 7'b0000000;
  localparam logic [6:0] P_BUSY = 7'b1110011;
  localparam logic [6:0] P_LOAD = 7'b1100100;
  localparam logic [6:0] P_DONE = 7'b0000001;
  localparam logic [6:0] P_BR   = 7'b0001100;
  localparam logic [6:0] P_PC   = 7'b1001000;
  localparam logic [6:0] P_PCW  = 7'b0001000;

  logic clk = 1'b0;
  logic reset;
  logic [NSRC*AW-1:0] RA_D, RA_E;
  logic [AW-1:0] WA_E, WA_M, WA_W;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MultiStartE;
  logic [NSRC*2-1:0] ForwardE;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy;
  logic [15:0] StallCount;
  logic [6:0] ctrl;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_cnt;
  logic [6:0] ctrl_q[$];
  logic [5:0] fwd_q[$];

  assign ctrl = {StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy};

  hazard_unit_mc #(.AW(AW), .NSRC(NSRC), .MC_LAT(4), .LD_LAT(2)) dut (
    .clk(clk), .reset(reset), .RA_D(RA_D), .RA_E(RA_E),
    .WA_E(WA_E), .WA_M(WA_M), .WA_W(WA_W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
    .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .MultiStartE(MultiStartE),
    .ForwardE(ForwardE), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .McBusy(McBusy),
    .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    RA_D = '0; RA_E = '0; WA_E = '0; WA_M = '0; WA_W = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0;
    BranchTakenE = 0; MultiStartE = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    RegWriteM = 1; PCSrcD = 1; BranchTakenE = 1; MultiStartE = 1;
    MemtoRegE = 1; RegWriteE = 1;
    #3;
    total++; if (ctrl !== P_NONE) begin bad++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, P_NONE); end
    total++; if (ForwardE !== 6'b0) begin bad++; $display("FAIL reset_fwd got=%b exp=%b", ForwardE, 6'b0); end
    tick(); tick();
    total++; if (ctrl !== P_NONE) begin bad++; $display("FAIL reset_ctrl_clk got=%b exp=%b", ctrl, P_NONE); end
    total++; if (StallCount !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%h exp=%h", StallCount, 16'd0); end
    clear_inputs();
    reset = 1'b1;
    exp_cnt = 16'd0;
  endtask

  task automatic test_forward();
    logic [6:0] ec;
    logic [5:0] ef;
    for (int c = 0; c < 4; c++) begin
      tick();
      clear_inputs();
      RA_E = {4'd3, 4'd7, 4'd3}; WA_M = 4'd3; WA_W = 4'd3;
      case (c)
        0: begin RegWriteM = 1; RegWriteW = 1; fwd_q.push_back(6'b10_00_10); end
        1: begin RegWriteW = 1; fwd_q.push_back(6'b01_00_01); end
        2: begin RegWriteM = 1; RegWriteW = 1; WA_W = 4'd7; fwd_q.push_back(6'b10_01_10); end
        default: begin RegWriteM = 1; WA_M = 4'd7; fwd_q.push_back(6'b00_10_00); end
      endcase
      ctrl_q.push_back(P_NONE);
      #3;
      ef = fwd_q.pop_front();
      ec = ctrl_q.pop_front();
      total++; if (ForwardE !== ef) begin bad++; $display("FAIL fwd cyc=%0d got=%b exp=%b", c, ForwardE, ef); end
      total++; if (ctrl !== ec) begin bad++; $display("FAIL fwd_ctrl cyc=%0d got=%b exp=%b", c, ctrl, ec); end
    end
  endtask

  task automatic test_load_use();
    logic [6:0] ec;
    for (int c = 0; c < 7; c++) begin
      tick();
      clear_inputs();
      WA_E = 4'd5;
      RA_D = (c >= 4) ? {4'd5, 4'd2, 4'd1} : {4'd9, 4'd5, 4'd1};
      case (c)
        0: begin MemtoRegE = 1; ctrl_q.push_back(P_NONE); end
        1, 4: begin MemtoRegE = 1; RegWriteE = 1; ctrl_q.push_back(P_LOAD); end
        2, 5: ctrl_q.push_back(P_LOAD);
        default: ctrl_q.push_back(P_NONE);
      endcase
      #3;
      ec = ctrl_q.pop_front();
      total++; if (ctrl !== ec) begin bad++; $display("FAIL load cyc=%0d got=%b exp=%b", c, ctrl, ec); end
      total++; if (StallCount !== exp_cnt) begin bad++; $display("FAIL load_cnt cyc=%0d got=%0d exp=%0d", c, StallCount, exp_cnt); end
      if (ec[6]) exp_cnt++;
    end
  endtask

  task automatic test_multicycle();
    logic [6:0] ec;
    for (int c = 0; c < 6; c++) begin
      tick();
      clear_inputs();
      MultiStartE = (c < 4);
      case (c)
        1, 2, 3: ctrl_q.push_back(P_BUSY);
        4: ctrl_q.push_back(P_DONE);
        default: ctrl_q.push_back(P_NONE);
      endcase
      #3;
      ec = ctrl_q.pop_front();
      total++; if (ctrl !== ec) begin bad++; $display("FAIL mc cyc=%0d got=%b exp=%b", c, ctrl, ec); end
      total++; if (StallCount !== exp_cnt) begin bad++; $display("FAIL mc_cnt cyc=%0d got=%0d exp=%0d", c, StallCount, exp_cnt); end
      if (ec[6]) exp_cnt++;
    end
  endtask

  task automatic test_collision();
    logic [6:0] ec;
    for (int c = 0; c < 3; c++) begin
      tick();
      clear_inputs();
      if (c == 0) begin
        MultiStartE = 1; BranchTakenE = 1; ctrl_q.push_back(P_BR);
      end else begin
        ctrl_q.push_back(P_NONE);
      end
      #3;
      ec = ctrl_q.pop_front();
      total++; if (ctrl !== ec) begin bad++; $display("FAIL collide cyc=%0d got=%b exp=%b", c, ctrl, ec); end
    end
  endtask

  task automatic test_pc_pending();
    logic [6:0] ec;
    for (int c = 0; c < 5; c++) begin
      tick();
      clear_inputs();
      case (c)
        0: begin PCSrcD = 1; ctrl_q.push_back(P_PC); end
        1: begin PCSrcE = 1; ctrl_q.push_back(P_PC); end
        2: begin PCSrcM = 1; ctrl_q.push_back(P_PC); end
        3: begin PCSrcW = 1; ctrl_q.push_back(P_PCW); end
        default: ctrl_q.push_back(P_NONE);
      endcase
      #3;
      ec = ctrl_q.pop_front();
      total++; if (ctrl !== ec) begin bad++; $display("FAIL pcsrc cyc=%0d got=%b exp=%b", c, ctrl, ec); end
      total++; if (StallCount !== exp_cnt) begin bad++; $display("FAIL pcsrc_cnt cyc=%0d got=%0d exp=%0d", c, StallCount, exp_cnt); end
      if (ec[6]) exp_cnt++;
    end
  endtask

  // Branch arriving during BUSY is held and takes effect in DONE
  task automatic test_back_to_back();
    logic [6:0] ec;
    for (int c = 0; c < 6; c++) begin
      tick();
      clear_inputs();
      MultiStartE = (c == 0);
      BranchTakenE = (c >= 1 && c <= 4);
      case (c)
        1, 2, 3: ctrl_q.push_back(P_BUSY);
        4: ctrl_q.push_back(P_DONE | P_BR);
        default: ctrl_q.push_back(P_NONE);
      endcase
      #3;
      ec = ctrl_q.pop_front();
      total++; if (ctrl !== ec) begin bad++; $display("FAIL b2b cyc=%0d got=%b exp=%b", c, ctrl, ec); end
      total++; if (StallCount !== exp_cnt) begin bad++; $display("FAIL b2b_cnt cyc=%0d got=%0d exp=%0d", c, StallCount, exp_cnt); end
      if (ec[6]) exp_cnt++;
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [6:0] ec;
    for (int c = 0; c < 3; c++) begin
      tick();
      clear_inputs();
      MultiStartE = (c == 0);
      ctrl_q.push_back((c == 0) ? P_NONE : P_BUSY);
      #3;
      ec = ctrl_q.pop_front();
      total++; if (ctrl !== ec) begin bad++; $display("FAIL rstbusy_pre cyc=%0d got=%b exp=%b", c, ctrl, ec); end
    end
    reset = 1'b0;
    RegWriteM = 1; PCSrcD = 1;
    #1;
    total++; if (ctrl !== P_NONE) begin bad++; $display("FAIL rstbusy_ctrl got=%b exp=%b", ctrl, P_NONE); end
    total++; if (ForwardE !== 6'b0) begin bad++; $display("FAIL rstbusy_fwd got=%b exp=%b", ForwardE, 6'b0); end
    total++; if (StallCount !== 16'd0) begin bad++; $display("FAIL rstbusy_cnt got=%0d exp=0", StallCount); end
    tick();
    clear_inputs();
    reset = 1'b1;
    exp_cnt = 16'd0;
    for (int c = 0; c < 5; c++) begin
      tick();
      ctrl_q.push_back(P_NONE);
      #3;
      ec = ctrl_q.pop_front();
      total++; if (ctrl !== ec) begin bad++; $display("FAIL rstbusy_post cyc=%0d got=%b exp=%b", c, ctrl, ec); end
    end
    total++; if (StallCount !== exp_cnt) begin bad++; $display("FAIL rstbusy_postcnt got=%0d exp=%0d", StallCount, exp_cnt); end
  endtask

  task automatic test_saturation();
    logic [6:0] ec;
    tick();
    clear_inputs();
    MemtoRegE = 1; RegWriteE = 1; WA_E = 4'd6; RA_D = {4'd0, 4'd0, 4'd6};
    for (int i = 0; i < 70000; i++) begin
      ctrl_q.push_back(P_LOAD);
      #3;
      ec = ctrl_q.pop_front();
      total++; if (StallCount !== exp_cnt) begin bad++; $display("FAIL sat_cnt i=%0d got=%h exp=%h", i, StallCount, exp_cnt); end
      if (i == 0 || i == 69999) begin
        total++; if (ctrl !== ec) begin bad++; $display("FAIL sat_ctrl i=%0d got=%b exp=%b", i, ctrl, ec); end
      end
      if (ec[6] && exp_cnt != 16'hFFFF) exp_cnt++;
      tick();
    end
    clear_inputs();
    for (int c = 0; c < 4; c++) tick();
    #3;
    total++; if (StallCount !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=%h", StallCount, 16'hFFFF); end
    total++; if (ctrl !== P_NONE) begin bad++; $display("FAIL sat_idle got=%b exp=%b", ctrl, P_NONE); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_multicycle();
    test_collision();
    test_pc_pending();
    test_back_to_back();
    test_reset_mid_busy();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
